// File: rtl/mips_multi_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// State encodings are fixed because state_o exposes them for debug.
package mips_multi_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       i_or_d;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       branch_ne;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    // States that talk to memory and therefore wait on the handshake.
    function automatic logic is_mem_state(input state_t s);
        logic r;
        case (s)
            S_FETCH, S_MEMRD, S_MEMWR: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_multi_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath, with a variable-latency
// memory handshake and a bounded wait-state timeout that sets a sticky bus_err.
module mips_multi_ctrl
    import mips_multi_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int MEM_WAIT_EN = 1,
    parameter int WAIT_MAX    = 15,
    parameter int BNE_EN      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            i_or_d,
    output logic            alusrc_a,
    output logic [1:0]      alusrc_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            mem_write,
    output logic            reg_write,
    output logic            branch,
    output logic            branch_ne,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            illegal_op,
    output logic            bus_err,
    output logic [3:0]      state_o
);

    localparam logic [OP_W-1:0] OPC_R    = OP_W'(OP_R);
    localparam logic [OP_W-1:0] OPC_LW   = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] OPC_SW   = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] OPC_BNE  = OP_W'(OP_BNE);
    localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(OP_ADDI);
    localparam logic [OP_W-1:0] OPC_J    = OP_W'(OP_J);
    localparam logic [7:0]      WAIT_LIM = 8'(WAIT_MAX);
    localparam logic            WAIT_ON  = (MEM_WAIT_EN != 0);
    localparam logic            BNE_ON   = (BNE_EN != 0);

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_next_s;
    logic       bus_err_r;
    logic       rdy_s;
    logic       stall_s;
    logic       timeout_s;
    logic       illegal_s;
    ctrl_t      ctl_s;
    ctrl_t      ctl_out_s;

    // Single-cycle memory builds treat every access as complete.
    assign rdy_s     = WAIT_ON ? mem_ready : 1'b1;
    assign stall_s   = WAIT_ON & is_mem_state(state_r) & ~rdy_s;
    assign timeout_s = stall_s & (wait_cnt_r == WAIT_LIM);

    // State, wait counter and sticky bus error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            bus_err_r  <= bus_err_r | timeout_s;
        end
    end

    // Wait counter restarts whenever a memory state is (re-)entered.
    always_comb begin
        wait_cnt_next_s = 8'd0;
        if (stall_s && !timeout_s) begin
            wait_cnt_next_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_next_s = 8'd0;
        end
    end

    // Next-state logic and opcode decode.
    always_comb begin
        state_next_s = state_r;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (rdy_s) state_next_s = S_DECODE;
                else       state_next_s = S_FETCH;
            end
            S_DECODE: begin
                if (op == OPC_LW || op == OPC_SW) begin
                    state_next_s = S_MEMADR;
                end else if (op == OPC_R) begin
                    state_next_s = S_RTYPEEX;
                end else if (op == OPC_BEQ || (BNE_ON && op == OPC_BNE)) begin
                    state_next_s = S_BRANCH;
                end else if (op == OPC_ADDI) begin
                    state_next_s = S_ADDIEX;
                end else if (op == OPC_J) begin
                    state_next_s = S_JUMP;
                end else begin
                    illegal_s    = 1'b1;
                    state_next_s = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (op == OPC_SW) state_next_s = S_MEMWR;
                else              state_next_s = S_MEMRD;
            end
            S_MEMRD: begin
                if (rdy_s)          state_next_s = S_MEMWB;
                else if (timeout_s) state_next_s = S_FETCH;
                else                state_next_s = S_MEMRD;
            end
            S_MEMWB:   state_next_s = S_FETCH;
            S_MEMWR: begin
                if (rdy_s || timeout_s) state_next_s = S_FETCH;
                else                    state_next_s = S_MEMWR;
            end
            S_RTYPEEX: state_next_s = S_RTYPEWB;
            S_RTYPEWB: state_next_s = S_FETCH;
            S_BRANCH:  state_next_s = S_FETCH;
            S_ADDIEX:  state_next_s = S_ADDIWB;
            S_ADDIWB:  state_next_s = S_FETCH;
            S_JUMP:    state_next_s = S_FETCH;
            default:   state_next_s = S_FETCH;
        endcase
    end

    // Moore output decode; fields not set in a state stay 0.
    always_comb begin
        ctl_s = '0;
        case (state_r)
            S_FETCH: begin
                ctl_s.mem_req  = 1'b1;
                ctl_s.alusrc_b = SRCB_FOUR;
                ctl_s.alu_op   = ALU_ADD;
                ctl_s.pc_src   = PCSRC_ALU;
                ctl_s.ir_write = rdy_s & ~timeout_s;
                ctl_s.pc_write = rdy_s & ~timeout_s;
            end
            S_DECODE: begin
                ctl_s.alusrc_b = SRCB_IMM_SH;
                ctl_s.alu_op   = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctl_s.alusrc_a = 1'b1;
                ctl_s.alusrc_b = SRCB_IMM;
                ctl_s.alu_op   = ALU_ADD;
            end
            S_MEMRD: begin
                ctl_s.mem_req = 1'b1;
                ctl_s.i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                ctl_s.mem_to_reg = 1'b1;
                ctl_s.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctl_s.mem_req   = 1'b1;
                ctl_s.i_or_d    = 1'b1;
                ctl_s.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                ctl_s.alusrc_a = 1'b1;
                ctl_s.alusrc_b = SRCB_B;
                ctl_s.alu_op   = ALU_FUNCT;
            end
            S_RTYPEWB: begin
                ctl_s.reg_dst   = 1'b1;
                ctl_s.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl_s.alusrc_a  = 1'b1;
                ctl_s.alusrc_b  = SRCB_B;
                ctl_s.alu_op    = ALU_SUB;
                ctl_s.pc_src    = PCSRC_ALUOUT;
                ctl_s.branch    = 1'b1;
                ctl_s.branch_ne = (op == OPC_BNE);
            end
            S_ADDIWB:  ctl_s.reg_write = 1'b1;
            S_JUMP: begin
                ctl_s.pc_src   = PCSRC_JUMP;
                ctl_s.pc_write = 1'b1;
            end
            default: ctl_s = '0;
        endcase
    end

    // Reset holds every enable low regardless of the current state.
    always_comb begin
        ctl_out_s = ctl_s;
        if (reset) begin
            ctl_out_s.mem_req   = 1'b0;
            ctl_out_s.ir_write  = 1'b0;
            ctl_out_s.pc_write  = 1'b0;
            ctl_out_s.mem_write = 1'b0;
            ctl_out_s.reg_write = 1'b0;
            ctl_out_s.branch    = 1'b0;
        end else begin
            ctl_out_s = ctl_s;
        end
    end

    assign mem_req    = ctl_out_s.mem_req;
    assign i_or_d     = ctl_out_s.i_or_d;
    assign alusrc_a   = ctl_out_s.alusrc_a;
    assign alusrc_b   = ctl_out_s.alusrc_b;
    assign alu_op     = ctl_out_s.alu_op;
    assign pc_src     = ctl_out_s.pc_src;
    assign ir_write   = ctl_out_s.ir_write;
    assign pc_write   = ctl_out_s.pc_write;
    assign mem_write  = ctl_out_s.mem_write;
    assign reg_write  = ctl_out_s.reg_write;
    assign branch     = ctl_out_s.branch;
    assign branch_ne  = ctl_out_s.branch_ne;
    assign reg_dst    = ctl_out_s.reg_dst;
    assign mem_to_reg = ctl_out_s.mem_to_reg;
    assign illegal_op = illegal_s;
    assign bus_err    = bus_err_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Randomised bench for mips_multi_ctrl: an instruction-level model (per-opcode
// state paths plus wait/timeout bookkeeping) predicts every cycle's outputs.
module tb_mips_multi_ctrl;

    localparam int WAIT_MAX = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    logic       mem_req, i_or_d, alusrc_a, ir_write, pc_write, mem_write, reg_write;
    logic       branch, branch_ne, reg_dst, mem_to_reg, illegal_op, bus_err;
    logic [1:0] alusrc_b, alu_op, pc_src;
    logic [3:0] state_o;

    logic       reset_nb = 1'b1;
    logic [5:0] op_nb = 6'b000101;
    logic       mem_req_nb, i_or_d_nb, alusrc_a_nb, ir_write_nb, pc_write_nb, mem_write_nb;
    logic       reg_write_nb, branch_nb, branch_ne_nb, reg_dst_nb, mem_to_reg_nb;
    logic       illegal_op_nb, bus_err_nb;
    logic [1:0] alusrc_b_nb, alu_op_nb, pc_src_nb;
    logic [3:0] state_o_nb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_multi_ctrl #(.OP_W(6), .MEM_WAIT_EN(1), .WAIT_MAX(WAIT_MAX), .BNE_EN(1)) u_dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .i_or_d(i_or_d), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .alu_op(alu_op), .pc_src(pc_src), .ir_write(ir_write), .pc_write(pc_write),
        .mem_write(mem_write), .reg_write(reg_write), .branch(branch), .branch_ne(branch_ne),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .bus_err(bus_err), .state_o(state_o)
    );

    mips_multi_ctrl #(.OP_W(6), .MEM_WAIT_EN(1), .WAIT_MAX(WAIT_MAX), .BNE_EN(0)) u_dut_nb (
        .clk(clk), .reset(reset_nb), .op(op_nb), .mem_ready(1'b1),
        .mem_req(mem_req_nb), .i_or_d(i_or_d_nb), .alusrc_a(alusrc_a_nb), .alusrc_b(alusrc_b_nb),
        .alu_op(alu_op_nb), .pc_src(pc_src_nb), .ir_write(ir_write_nb), .pc_write(pc_write_nb),
        .mem_write(mem_write_nb), .reg_write(reg_write_nb), .branch(branch_nb),
        .branch_ne(branch_ne_nb), .reg_dst(reg_dst_nb), .mem_to_reg(mem_to_reg_nb),
        .illegal_op(illegal_op_nb), .bus_err(bus_err_nb), .state_o(state_o_nb)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: the instruction's path of states and a cursor into it.
    int         path[$];
    int         idx = 0;
    int         wcnt = 0;
    bit         berr_m = 1'b0;
    bit         model_valid = 1'b0;
    int         stall_f = 0;
    int         stall_m = 0;
    logic [5:0] cur_op = 6'b100011;

    function automatic bit is_legal(input logic [5:0] o);
        return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
               o == 6'b000101 || o == 6'b001000 || o == 6'b000010;
    endfunction

    function automatic void load_path(input logic [5:0] o);
        path = {0, 1};
        case (o)
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000000: begin path.push_back(6); path.push_back(7); end
            6'b000100, 6'b000101: path.push_back(8);
            6'b001000: begin path.push_back(9); path.push_back(10); end
            6'b000010: path.push_back(11);
            default: ;
        endcase
    endfunction

    // Expected control word, packed in the same order the bench reads the DUT.
    function automatic logic [17:0] exp_ctl(input int s, input bit rdy, input logic [5:0] o, input bit rst);
        bit mreq = 0, iord = 0, srca = 0, irw = 0, pcw = 0, mw = 0, rw = 0;
        bit br = 0, brne = 0, rdst = 0, m2r = 0, ill = 0;
        logic [1:0] srcb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (s)
            0:  begin mreq = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'b11; ill = !is_legal(o); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mreq = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mreq = 1; iord = 1; mw = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; br = 1; brne = (o == 6'b000101); end
            9:  begin srca = 1; srcb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (rst) begin mreq = 0; irw = 0; pcw = 0; mw = 0; rw = 0; br = 0; end
        return {mreq, iord, srca, srcb, aop, pcs, irw, pcw, mw, rw, br, brne, rdst, m2r, ill};
    endfunction

    task automatic tick(input bit rst);
        int s;
        bit rdy;
        bit mem_s;
        @(negedge clk);
        reset = rst;
        s = (idx < path.size()) ? path[idx] : 0;
        mem_s = (s == 0 || s == 3 || s == 5);
        if (rst) begin
            rdy = 1'b1;
        end else if (s == 0) begin
            rdy = (stall_f == 0);
            if (stall_f > 0) stall_f--;
        end else if (mem_s) begin
            rdy = (stall_m == 0);
            if (stall_m > 0) stall_m--;
        end else begin
            rdy = 1'($urandom_range(0, 1));
        end
        mem_ready = rdy;
        op = cur_op;
        #1;
        if (model_valid) begin
            check_val($sformatf("state(op=%b)", cur_op), 32'(state_o), 32'(s));
            check_val($sformatf("ctl(s=%0d)", s),
                      32'({mem_req, i_or_d, alusrc_a, alusrc_b, alu_op, pc_src, ir_write, pc_write,
                           mem_write, reg_write, branch, branch_ne, reg_dst, mem_to_reg, illegal_op}),
                      32'(exp_ctl(s, rdy, cur_op, rst)));
            check_val("bus_err", 32'(bus_err), 32'(berr_m));
        end
        if (rst) begin
            idx = 0; wcnt = 0; berr_m = 1'b0; model_valid = 1'b1;
        end else if (mem_s && !rdy) begin
            if (wcnt == WAIT_MAX) begin
                berr_m = 1'b1; idx = 0; wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            idx++; wcnt = 0;
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input int sf, input int sm);
        int k;
        cur_op = o;
        load_path(o);
        idx = 0; wcnt = 0; stall_f = sf; stall_m = sm;
        k = 0;
        while (idx < path.size() && k < 200) begin
            tick(1'b0);
            k++;
        end
        if (idx < path.size()) check_val("instr_budget", 32'(idx), 32'(path.size()));
    endtask

    // BNE_EN=0 instance: BNE is illegal while BEQ still branches.
    initial begin
        repeat (2) @(negedge clk);
        reset_nb = 1'b0;
        #1 check_val("nb_fetch", 32'(state_o_nb), 32'd0);
        @(negedge clk); #1;
        check_val("nb_decode", 32'(state_o_nb), 32'd1);
        check_val("nb_illegal", 32'(illegal_op_nb), 32'd1);
        @(negedge clk); #1;
        check_val("nb_back_fetch", 32'(state_o_nb), 32'd0);
        check_val("nb_illegal_clr", 32'(illegal_op_nb), 32'd0);
        op_nb = 6'b000100;
        @(negedge clk); #1;
        check_val("nb_beq_decode", 32'(illegal_op_nb), 32'd0);
        @(negedge clk); #1;
        check_val("nb_beq_branch", 32'(state_o_nb), 32'd8);
        check_val("nb_beq_flags", 32'({branch_nb, branch_ne_nb}), 32'b10);
    end

    initial begin
        logic [5:0] legal_ops [7];
        logic [5:0] o;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
        load_path(cur_op);
        tick(1'b1);
        tick(1'b1);
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000101, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 4, 0);
        check_val("bus_err_set", 32'(bus_err), 32'd1);
        tick(1'b1);
        tick(1'b1);
        run_instr(6'b001000, 0, 0);
        check_val("bus_err_cleared", 32'(bus_err), 32'd0);
        run_instr(6'b100011, 0, 6);
        run_instr(6'b101011, 0, 5);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 63));
            else o = legal_ops[$urandom_range(0, 6)];
            run_instr(o, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0,
                         ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0);
            if ($urandom_range(0, 40) == 0) begin
                tick(1'b1);
                tick(1'b1);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_multi_ctrl.md
Name: mips_multi_ctrl

Overview:
- Parametrised successor to the multicycle MIPS main decoder.
- A Moore control FSM that drives the multicycle datapath (PC, IR, register file, ALU muxes, unified memory) for LW, SW, R-type, BEQ, BNE (optional), ADDI and J.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a bounded wait-state timeout.
- Every control output has a defined value in every state: unlisted outputs are 0, with no latching.

Parameters:
- OP_W, 6, opcode field width.
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1 (single-cycle memory).
- WAIT_MAX, 15, maximum wait cycles in any memory state before timeout; 1..255.
- BNE_EN, 1, 1 = decode BNE (000101); 0 = BNE is illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  OP_W  instruction opcode from IR.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access active.
- i_or_d  out  1  address select, 0 = PC, 1 = ALUOut.
- alusrc_a  out  1  0 = PC, 1 = A.
- alusrc_b  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ir_write, pc_write, mem_write, reg_write  out  1 each  write enables.
- branch  out  1  conditional PC write.
- branch_ne  out  1  invert zero test (BNE).
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = data.
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode.
- bus_err  out  1  sticky; set on memory timeout.
- state_o  out  4  current state, for debug.

Behaviour:
- State register updates on posedge clk. reset=1 at an edge forces state FETCH, clears wait_cnt and clears bus_err.
- While reset=1, all enables (mem_req, ir_write, pc_write, mem_write, reg_write, branch) are forced to 0.
- Outputs decode combinationally from state. rdy = mem_ready when MEM_WAIT_EN=1, else 1.
- FETCH (0):
  - Outputs: mem_req=1, i_or_d=0, alusrc_a=0, alusrc_b=01, alu_op=00, pc_src=00, ir_write=pc_write=rdy.
  - Transition: rdy → DECODE, else stay.
- DECODE (1):
  - Outputs: alusrc_a=0, alusrc_b=11, alu_op=00.
  - Transition on op: LW/SW → MEMADR; R (000000) → RTYPEEX; BEQ, or BNE with BNE_EN → BRANCH; ADDI (001000) → ADDIEX; J (000010) → JUMP; otherwise illegal_op=1 and → FETCH.
- MEMADR (2):
  - Outputs: alusrc_a=1, alusrc_b=10, alu_op=00.
  - Transition: SW → MEMWR, else → MEMRD.
- MEMRD (3):
  - Outputs: mem_req=1, i_or_d=1.
  - Transition: rdy → MEMWB.
- MEMWB (4):
  - Outputs: reg_dst=0, mem_to_reg=1, reg_write=1.
  - Transition: → FETCH.
- MEMWR (5):
  - Outputs: mem_req=1, i_or_d=1, mem_write=1. mem_write stays high until rdy.
  - Transition: rdy → FETCH.
- RTYPEEX (6):
  - Outputs: alusrc_a=1, alusrc_b=00, alu_op=10.
  - Transition: → RTYPEWB.
- RTYPEWB (7):
  - Outputs: reg_dst=1, mem_to_reg=0, reg_write=1.
  - Transition: → FETCH.
- BRANCH (8):
  - Outputs: alusrc_a=1, alusrc_b=00, alu_op=01, pc_src=01, branch=1, branch_ne=(op==000101).
  - Transition: → FETCH.
- ADDIEX (9):
  - Outputs: alusrc_a=1, alusrc_b=10, alu_op=00.
  - Transition: → ADDIWB.
- ADDIWB (10):
  - Outputs: reg_dst=0, mem_to_reg=0, reg_write=1.
  - Transition: → FETCH.
- JUMP (11):
  - Outputs: pc_src=10, pc_write=1.
  - Transition: → FETCH.
- Unused encodings 12–15 → FETCH on the next edge, with all outputs 0.
- Cycle counts with zero wait states: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3.
- Wait counter (8 bit):
  - Cleared on entry to any memory state (FETCH, MEMRD, MEMWR).
  - Increments on each memory-state cycle where rdy=0.
  - If wait_cnt==WAIT_MAX and rdy=0: bus_err is set, state → FETCH, and this cycle's enables are suppressed, so fetch retries the same PC.
  - rdy=1 in the same cycle as the limit counts as success.
- Timeout in MEMWR aborts the store: mem_write deasserts the next cycle.
- With MEM_WAIT_EN=0, the counter is held at 0 and bus_err never sets.
- op is sampled only in DECODE, MEMADR and BRANCH; IR is stable in those states.

Decomposition:
- Package mips_multi_pkg holds:
  - state_t enum with the explicit 4-bit encodings above;
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - ALU-op and mux-select constants.
- Single module, no sub-module. Next-state logic and output decode are separate combinational blocks, with default assignments at the top.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 → state_o=0, mem_req=1, ir_write=pc_write=1, alusrc_b=01, bus_err=0.
- LW (100011) with mem_ready=1 → states 0,1,2,3,4,0. reg_write=1 only in cycle 5, with mem_to_reg=1 and reg_dst=0.
- SW with mem_ready low 3 cycles in MEMWR → mem_write high for 4 cycles, then FETCH. bus_err stays 0.
- BNE (000101), BNE_EN=1 → DECODE then BRANCH with branch=1, branch_ne=1, alu_op=01, pc_src=01. With BNE_EN=0 → illegal_op pulse, back to FETCH.
- WAIT_MAX=3, mem_ready stuck 0 in FETCH → after 4 wait cycles bus_err=1, no ir_write, re-enter FETCH. Subsequent reset clears bus_err.
- R-type, then J, back to back → R: 0,1,6,7 (reg_dst=1 in state 7). J: 0,1,11 with pc_src=10 and pc_write=1.
